// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor.
// Operands are loaded in parallel on an accepted start. One full-adder cell
// with a registered carry then consumes one bit per clock, LSB first, and the
// result is shifted into the sum register from the top. Subtraction is done
// as a + ~b + 1, with the +1 supplied as the initial carry.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             load, step, last;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             s_bit, c_bit;

  // Carry-out of a full-adder cell.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Sum bit of a full-adder cell.
  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  assign s_bit = fa_sum(sha_q[0], shb_q[0], carry_q);
  assign c_bit = maj3(sha_q[0], shb_q[0], carry_q);
  assign last  = (cnt_q == LAST_CNT);

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is honoured only in IDLE and FIN, so a start
  // during RUN never reloads the operands.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_d = FIN;
        end
      end
      FIN: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: load operands, or step one bit through the adder.
  // The flags are captured only on the last bit, so they stay valid from
  // done until the last bit of the following operation.
  always_comb begin
    sha_d   = sha_q;
    shb_d   = shb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (load) begin
      sha_d   = a;
      shb_d   = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = '0;
    end else if (step) begin
      sha_d   = sha_q >> 1;
      shb_d   = shb_q >> 1;
      sum_d   = {s_bit, sum_q[WIDTH-1:1]};
      carry_d = c_bit;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last) begin
        // carry_q is the carry into the MSB at this point.
        cout_d = c_bit;
        ovf_d  = carry_q ^ c_bit;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sha_q   <= '0;
      shb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: an 8-bit and a 16-bit instance, driven with
// directed and random operations and compared against an arithmetic model.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int tests_run = 0;
  int tests_failed = 0;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] av,
                                         input logic [31:0] bv, input logic sv);
    longint m, ua, ub, r, sa, sb, rs;
    logic c, o;
    logic [31:0] s;
    m  = longint'(1) << w;
    ua = longint'({32'd0, av}) & (m - 1);
    ub = longint'({32'd0, bv}) & (m - 1);
    r  = sv ? (ua - ub) : (ua + ub);
    c  = sv ? (ua >= ub) : (r >= m);
    s  = 32'(r & (m - 1));
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    rs = sv ? (sa - sb) : (sa + sb);
    o  = (rs >= m / 2) || (rs < -(m / 2));
    return {o, c, s};
  endfunction

  task automatic drive(input int w, input logic st, input logic [31:0] av,
                       input logic [31:0] bv, input logic sv);
    if (w == 16) begin
      start16 = st; a16 = av[15:0]; b16 = bv[15:0]; sub16 = sv;
    end else begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv;
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn,
                        output logic cy, output logic ov, output logic [31:0] sm);
    if (w == 16) begin
      bz = busy16; dn = done16; cy = cout16; ov = ovf16; sm = {16'd0, sum16};
    end else begin
      bz = busy8; dn = done8; cy = cout8; ov = ovf8; sm = {24'd0, sum8};
    end
  endtask

  // One operation; optionally pulse start with other operands at cycle intf_k.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input int intf_k, input logic [31:0] ia,
                        input logic [31:0] ib, input string tag);
    logic [33:0] exp;
    logic bz, dn, cy, ov, cy_d, ov_d;
    logic [31:0] sm, sum_d, sum_hold;
    int first_done, ndone, nbusy, nboth;
    exp = ref_op(w, av, bv, sv);
    first_done = -1; ndone = 0; nbusy = 0; nboth = 0;
    cy_d = 1'bx; ov_d = 1'bx; sum_d = 'x; sum_hold = 'x;
    @(negedge clk);
    drive(w, 1'b1, av, bv, sv);
    for (int k = 0; k <= w + 2; k++) begin
      @(negedge clk);
      sample(w, bz, dn, cy, ov, sm);
      if (dn) begin
        ndone++;
        if (first_done < 0) begin
          first_done = k; sum_d = sm; cy_d = cy; ov_d = ov;
        end
      end
      if (bz) nbusy++;
      if (bz && dn) nboth++;
      if (k == w + 2) sum_hold = sm;
      if (k == intf_k) drive(w, 1'b1, ia, ib, ~sv);
      else if (k == 0 || k == intf_k + 1) drive(w, 1'b0, av, bv, sv);
    end
    check_val({tag, ".latency"}, 32'(first_done), 32'(w));
    check_val({tag, ".ndone"}, 32'(ndone), 32'd1);
    check_val({tag, ".busy_cycles"}, 32'(nbusy), 32'(w));
    check_val({tag, ".busy_and_done"}, 32'(nboth), 32'd0);
    check_val({tag, ".sum"}, sum_d, exp[31:0]);
    check_val({tag, ".cout"}, {31'd0, cy_d}, {31'd0, exp[32]});
    check_val({tag, ".ovf"}, {31'd0, ov_d}, {31'd0, exp[33]});
    check_val({tag, ".sum_hold"}, sum_hold, exp[31:0]);
  endtask

  // Start held high: done must recur every w+1 cycles.
  task automatic run_b2b(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input int nops, input string tag);
    logic [33:0] exp;
    logic bz, dn, cy, ov;
    logic [31:0] sm;
    int ndone;
    exp = ref_op(w, av, bv, sv);
    ndone = 0;
    @(negedge clk);
    drive(w, 1'b1, av, bv, sv);
    for (int k = 0; k <= (nops - 1) * (w + 1) + w; k++) begin
      @(negedge clk);
      sample(w, bz, dn, cy, ov, sm);
      if (dn) begin
        check_val({tag, ".done_pos"}, 32'(k), 32'(w + ndone * (w + 1)));
        check_val({tag, ".sum"}, sm, exp[31:0]);
        check_val({tag, ".cout"}, {31'd0, cy}, {31'd0, exp[32]});
        ndone++;
      end
    end
    drive(w, 1'b0, av, bv, sv);
    check_val({tag, ".ndone"}, 32'(ndone), 32'(nops));
    @(negedge clk);
    sample(w, bz, dn, cy, ov, sm);
    check_val({tag, ".idle_after"}, {30'd0, bz, dn}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    int ndone;
    rst_n = 1'b0;
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(16, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("reset.busy", {31'd0, busy8}, 32'd0);
    check_val("reset.done", {31'd0, done8}, 32'd0);
    check_val("reset.sum", {24'd0, sum8}, 32'd0);
    check_val("reset.cout", {31'd0, cout8}, 32'd0);
    check_val("reset.ovf", {31'd0, ovf8}, 32'd0);
    check_val("reset.busy16", {31'd0, busy16}, 32'd0);
    rst_n = 1'b1;

    // Directed arithmetic cases
    run_op(8, 32'h3C, 32'h0F, 1'b0, -1, 0, 0, "add_3c_0f");
    run_op(8, 32'hFF, 32'h01, 1'b0, -1, 0, 0, "add_ff_01");
    run_op(8, 32'h7F, 32'h01, 1'b0, -1, 0, 0, "add_7f_01");
    run_op(8, 32'h05, 32'h07, 1'b1, -1, 0, 0, "sub_05_07");
    run_op(8, 32'h80, 32'h01, 1'b1, -1, 0, 0, "sub_80_01");
    run_op(8, 32'h00, 32'h00, 1'b1, -1, 0, 0, "sub_00_00");

    // Start while busy must be ignored
    run_op(8, 32'h01, 32'h02, 1'b0, 3, 32'h10, 32'h20, "ignore_busy");

    // Reset mid-operation
    @(negedge clk);
    drive(8, 1'b1, 32'h01, 32'h02, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 32'h01, 32'h02, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midreset.outs", {20'd0, busy8, done8, cout8, ovf8, sum8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check_val("midreset.no_done", 32'(ndone), 32'd0);
    run_op(8, 32'hAA, 32'h55, 1'b0, -1, 0, 0, "after_reset");

    // Random operations
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_op(8, ra, rb, rs, -1, 0, 0, "rand8");
    end
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_op(16, ra, rb, rs, -1, 0, 0, "rand16");
    end
    run_op(16, 32'h8000, 32'h0001, 1'b1, -1, 0, 0, "sub16_8000_0001");

    // Back-to-back throughput
    run_b2b(8, 32'h01, 32'h01, 1'b0, 4, "b2b8");
    run_b2b(16, 32'hFFFF, 32'h0001, 1'b0, 3, "b2b16");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial, parametrised adder/subtractor. It is the sequential successor to the team's combinational half/full-adder circuits.
- Operands load in parallel on a start handshake and are processed LSB-first through one full-adder cell with a registered carry, one bit per clock.
- Produces a WIDTH-bit result, carry-out and signed overflow, with a one-cycle done pulse.
- Used wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk when busy=0.
- sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; holds until the next accepted start.
- cout  output  1  final carry-out. For sub, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Operand shift registers, carry flop and counter all cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced afterwards.
- States:
  - IDLE: waiting for start.
  - RUN: one bit processed per cycle.
  - FIN: one cycle; done=1.
- Transitions:
  - IDLE, start=1: go to RUN. Load shA=a, shB = sub ? ~b : b, carry=sub, cnt=0, busy=1.
  - RUN, each edge:
    - s = shA[0]^shB[0]^carry.
    - carry = majority(shA[0], shB[0], carry).
    - Shift shA and shB right by 1.
    - Shift the sum register right, inserting s at its MSB.
    - cnt=cnt+1.
    - On the edge where cnt reaches WIDTH-1 (last bit), go to FIN.
  - On the transition into FIN, register: cout = final carry; ovf = (carry before the MSB step) XOR (final carry); done=1; busy=0.
  - FIN: done deasserts on the next edge. Next state is RUN if start=1 (back-to-back accepted, same load as IDLE), else IDLE.
- Latency: start sampled at edge E0; done is high in the cycle following edge E_WIDTH. This gives a throughput of one operation per WIDTH+1 cycles.
- start while busy=1: ignored; a, b and sub are not resampled.
- sum/cout/ovf:
  - Update only on the edge entering FIN.
  - Stable from then until WIDTH edges after the next accepted start.
  - The visible sum is the internal shift register; it changes during RUN. Consumers sample it only on done.
- Arithmetic is modulo 2^WIDTH. Operands are unsigned for cout and two's complement for ovf.
- done and busy are never both high.

Test Plan:
- WIDTH=8, start with a=0x3C, b=0x0F, sub=0 -> done exactly 8 cycles after the start edge; sum=0x4B, cout=0, ovf=0; busy high for 8 cycles.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Pulse start with a=0x10, b=0x20 while busy (3 cycles after the first start of a=0x01, b=0x02) -> second start ignored; single done with sum=0x03.
- Assert rst_n=0 for 1 cycle mid-RUN -> all outputs 0 immediately, no done. New start afterwards with a=0xAA, b=0x55 -> sum=0xFF, cout=0.
- Hold start=1 continuously with a=0x01, b=0x01 -> done pulses every 9 cycles with sum=0x02. Repeat at WIDTH=16 with a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, latency 16.
